// File: rtl/rtu_rob_ctrl.sv
// Reorder-buffer head/tail controller for a 16-entry ROB.
// Allocates IIDs at the tail, retires in order from the head, and sequences
// a global flush (FLUSH then RECOVER) that resets the queue pointers.
// Protocol violations set a sticky error flag and are otherwise ignored.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | normal allocate/retire; any entry_flush bit starts a flush
// FLUSH   | one cycle of rtu_global_flush; pointers and count clear
// RECOVER | one cycle of rename-map recovery; grants and head ptr blocked
module rtu_rob_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_clk,
  input  logic        create_req,
  output logic        create_gnt,
  output logic [15:0] entry_create_vld,
  output logic [3:0]  create_iid,
  input  logic [15:0] entry_vld,
  input  logic [15:0] entry_retire,
  input  logic [15:0] entry_flush,
  output logic [15:0] head_iid_ptr,
  output logic        rtu_global_flush,
  output logic [4:0]  rob_cnt,
  output logic        rob_full,
  output logic        rob_empty,
  output logic        rob_err
);

  localparam int PTR_W = 4;

  typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

  state_t           state;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [4:0]       cnt;

  logic        run;
  logic        any_flush;
  logic        retire;
  logic        err_evt;
  logic [15:0] head_oh;
  logic [15:0] tail_oh;

  assign run       = (state == RUN);
  assign any_flush = |entry_flush;
  assign head_oh   = 16'd1 << head;
  assign tail_oh   = 16'd1 << tail;

  assign rob_cnt   = cnt;
  assign rob_full  = (cnt == 5'(DEPTH));
  assign rob_empty = (cnt == 5'd0);

  // Reset term keeps the grant quiet while the pointers are being forced.
  assign create_gnt       = create_req & ~rob_full & run & ~any_flush & ~rst_clk;
  assign entry_create_vld = create_gnt ? tail_oh : 16'd0;
  assign create_iid       = tail;

  // Head pointer is withheld whenever a flush is pending or in progress so
  // no wrong-path entry can retire.
  assign head_iid_ptr     = rst_clk ? 16'h0001 :
                            ((run & ~any_flush) ? head_oh : 16'd0);
  assign rtu_global_flush = (state == FLUSH);

  assign retire  = run & entry_retire[head];
  assign err_evt = (run & |(entry_retire & ~head_oh)) |
                   (run & |entry_retire & (cnt == 5'd0)) |
                   (create_gnt & entry_vld[tail]);

  // Pointer, count and flush sequencing; an erroneous cycle only sets rob_err.
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      state   <= RUN;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      rob_err <= 1'b0;
    end else if (err_evt) begin
      rob_err <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (create_gnt) tail <= tail + 4'd1;
          if (retire)     head <= head + 4'd1;
          case ({create_gnt, retire})
            2'b10:   cnt <= cnt + 5'd1;
            2'b01:   cnt <= cnt - 5'd1;
            default: cnt <= cnt;
          endcase
          if (any_flush) state <= FLUSH;
        end
        FLUSH: begin
          head  <= '0;
          tail  <= '0;
          cnt   <= '0;
          state <= RECOVER;
        end
        RECOVER: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/rtu_rob_ctrl.md
RTU_ROB_CTRL -- requirements
Module: rtu_rob_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, the number of ROB entries; the design is sized only for 16 (PTR_W=4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_clk, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port create_req, input, 1 bit: dispatch requests one ROB entry this cycle.
REQ-005 SHALL have port create_gnt, output, 1 bit: the allocation is accepted this cycle.
REQ-006 SHALL have port entry_create_vld, output, 16 bits: one-hot create strobe to the tail entry; equals one-hot(tail) when create_gnt=1, else 0.
REQ-007 SHALL have port create_iid, output, 4 bits: the tail index (IID) given to the granted instruction.
REQ-008 SHALL have port entry_vld, input, 16 bits: per-entry valid bits.
REQ-009 SHALL have port entry_retire, input, 16 bits: per-entry retire_vld.
REQ-010 SHALL have port entry_flush, input, 16 bits: per-entry flush_vld.
REQ-011 SHALL have port head_iid_ptr, output, 16 bits: one-hot head_iid_ptr_cur_vld to the entries.
REQ-012 SHALL have port rtu_global_flush, output, 1 bit: flush to all entries and the front end.
REQ-013 SHALL have port rob_cnt, output, 5 bits: occupied entries, 0..16.
REQ-014 SHALL have ports rob_full and rob_empty, output, 1 bit each.
REQ-015 SHALL have port rob_err, output, 1 bit: sticky protocol-error flag.

Function
REQ-016 SHALL keep registers head[3:0], tail[3:0], cnt[4:0] and a state in {RUN, FLUSH, RECOVER}.
REQ-017 SHALL drive rob_full=(cnt==16), rob_empty=(cnt==0) and rob_cnt=cnt, all from registers.
REQ-018 SHALL assert create_gnt=create_req & ~rob_full & (state==RUN) & ~|entry_flush; a retire in the same cycle does not free a slot for a full ROB.
REQ-019 SHALL, on create_gnt, advance tail by +1 modulo 16 (15 wraps to 0) at the next edge.
REQ-020 SHALL drive head_iid_ptr=one-hot(head) only in RUN with ~|entry_flush, and all-zero otherwise, so that no wrong-path entry retires.
REQ-021 SHALL treat entry_retire[head]=1 in RUN as a retire: head advances by +1 modulo 16 at the next edge.
REQ-022 SHALL update cnt as +1 on grant only, -1 on retire only, and leave it unchanged on simultaneous grant and retire.
REQ-023 SHALL, in RUN, go to FLUSH at the next edge when any entry_flush bit is high; any retire in that cycle is still counted.
REQ-024 SHALL, in FLUSH, assert rtu_global_flush=1 for exactly that one cycle, then clear head, tail and cnt to 0 and go to RECOVER.
REQ-025 SHALL, in RECOVER, block grants and head_iid_ptr for one cycle (rename-map recovery), then return to RUN.
REQ-026 SHALL ignore entry_retire and entry_flush while in FLUSH or RECOVER.
REQ-027 SHALL set rob_err, cleared only by reset, when any of these occurs:
- a retire bit other than head is seen in RUN;
- a grant is made while entry_vld[tail]=1;
- a retire is seen while cnt==0.
REQ-028 SHALL leave all state unchanged by any erroneous event except the setting of rob_err.

Reset
REQ-029 SHALL, while rst_clk=1, asynchronously force head=0, tail=0, cnt=0, state=RUN and rob_err=0.
REQ-030 SHALL drive these output values during reset:
- create_gnt=0, rtu_global_flush=0, rob_empty=1, rob_full=0;
- head_iid_ptr=16'h0001 and entry_create_vld=0.
REQ-031 SHALL, when reset asserts mid-FLUSH or mid-RECOVER, abandon the sequence; the first cycle after release is RUN.

Verification
REQ-032 Bench SHALL cover fill: create_req=1 for 17 cycles with no retire -> grants on cycles 1-16 with create_iid 0..15, rob_full=1 and no grant on cycle 17, rob_cnt=16.
REQ-033 Bench SHALL cover wrap: reach head=14, tail=14, then run 4 grants and 4 in-order retires -> create_iid 14,15,0,1, head_iid_ptr 0x4000,0x8000,0x0001,0x0002, rob_cnt returns to 0.
REQ-034 Bench SHALL cover simultaneous grant+retire at cnt=5 -> cnt stays 5 and head and tail both advance by 1.
REQ-035 Bench SHALL cover full+retire: cnt=16, create_req=1, entry_retire[head]=1 -> no grant that cycle, cnt=15; grant on the next cycle.
REQ-036 Bench SHALL cover flush: entry_flush[3]=1 with cnt=6:
- that cycle: head_iid_ptr=0, no grant;
- next cycle: rtu_global_flush=1 for one cycle;
- following cycle: RECOVER, no grant;
- then head=tail=cnt=0 and grants resume.
REQ-037 Bench SHALL cover errors and reset: entry_retire[head+2] -> rob_err=1 with head unchanged; asserting rst_clk mid-FLUSH -> rtu_global_flush drops immediately and rob_err=0.
